// File: rtl/parity_pkg.sv
// Shared defaults and FSM state encoding for the parity frame checker
// and any future generator built on the same word check.
package parity_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FRAME_LEN  = 4;
  localparam int DEF_ODD_PARITY = 0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCUM  = 2'd1;
  localparam state_t ST_RESYNC = 2'd2;

endpackage

// File: rtl/parity_word_check.sv
// Combinational single-word parity check: err is high when the transmitted
// parity bit disagrees with the parity computed over data.
module parity_word_check
  import parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  input  logic              odd,
  output logic              err
);

  assign err = par ^ (^data) ^ odd;

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming checker: forwards words with a per-word parity flag and tracks
// frame length and LRC, reporting each frame with a one-cycle frame_done pulse.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int ODD_PARITY = DEF_ODD_PARITY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              frame_done,
  output logic              frame_lrc_err,
  output logic              frame_len_err,
  input  logic              clear_count,
  output logic [15:0]       err_count
);

  localparam int               CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(FRAME_LEN);

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_inc;
  logic [DATA_W-1:0]   lrc;
  logic [DATA_W-1:0]   lrc_next;
  logic                accept;
  logic                word_err;

  // A held output word blocks intake unless it leaves this same cycle.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign count_inc = count + CNT_W'(1);
  assign lrc_next  = lrc ^ in_data;

  parity_word_check #(
    .DATA_W(DATA_W)
  ) u_word_check (
    .data(in_data),
    .par (in_par),
    .odd (ODD_PARITY != 0),
    .err (word_err)
  );

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values;
  // all state, including the datapath register, is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_par_err <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= in_data;
      out_par_err <= word_err;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      count         <= '0;
      lrc           <= '0;
      frame_done    <= 1'b0;
      frame_lrc_err <= 1'b0;
      frame_len_err <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      frame_lrc_err <= 1'b0;
      frame_len_err <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (in_last) begin
              // Single-word frame can never meet the minimum length of two.
              frame_done    <= 1'b1;
              frame_len_err <= 1'b1;
              frame_lrc_err <= (in_data != '0);
            end else begin
              state <= ST_ACCUM;
              count <= CNT_W'(1);
              lrc   <= in_data;
            end
          end
          ST_ACCUM: begin
            if (in_last) begin
              frame_done    <= 1'b1;
              frame_len_err <= (count_inc != LEN_C);
              frame_lrc_err <= (lrc_next != '0);
              state         <= ST_IDLE;
              count         <= '0;
              lrc           <= '0;
            end else if (count_inc == LEN_C) begin
              // Frame overran without in_last: report now, then drop words
              // until the sender's own in_last realigns us.
              frame_done    <= 1'b1;
              frame_len_err <= 1'b1;
              state         <= ST_RESYNC;
              count         <= '0;
              lrc           <= '0;
            end else begin
              count <= count_inc;
              lrc   <= lrc_next;
            end
          end
          ST_RESYNC: begin
            if (in_last) state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            count <= '0;
            lrc   <= '0;
          end
        endcase
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear_count) begin
      err_count <= '0;
    end else if (accept && word_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker (DATA_W=8, FRAME_LEN=4, even parity).
module tb_parity_frame_checker;

  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
  } exp_word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_par;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_par_err;
  logic          frame_done;
  logic          frame_lrc_err;
  logic          frame_len_err;
  logic          clear_count;
  logic [15:0]   err_count;

  exp_word_t   exp_q[$];
  logic [1:0]  frame_q[$];  // {lrc_err, len_err}
  int          n_checks = 0;
  int          n_errors = 0;

  parity_frame_checker #(
    .DATA_W    (DW),
    .FRAME_LEN (4),
    .ODD_PARITY(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_par       (in_par),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_par_err  (out_par_err),
    .frame_done   (frame_done),
    .frame_lrc_err(frame_lrc_err),
    .frame_len_err(frame_len_err),
    .clear_count  (clear_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected output is queued as the word is presented (even parity model).
  task automatic send_word(input logic [DW-1:0] d, input logic p, input logic l);
    logic rdy;
    logic done;
    exp_word_t e;
    done   = 1'b0;
    e.data = d;
    e.perr = p ^ (^d);
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("accept_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic good_frame();
    frame_q.push_back(2'b00);
    send_word(8'h0F, 1'b0, 1'b0);
    send_word(8'h07, 1'b1, 1'b0);
    send_word(8'h01, 1'b1, 1'b0);
    send_word(8'h09, 1'b0, 1'b1);
  endtask

  // Output monitor: a transfer seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    exp_word_t  e;
    logic [1:0] f;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'b0, out_data}, {24'b0, e.data});
          check("out_par_err", {31'b0, out_par_err}, {31'b0, e.perr});
        end
      end
      if (frame_done) begin
        if (frame_q.size() == 0) begin
          check("unexpected_done", {31'b0, frame_done}, 32'd0);
        end else begin
          f = frame_q.pop_front();
          check("frame_lrc_err", {31'b0, frame_lrc_err}, {31'b0, f[1]});
          check("frame_len_err", {31'b0, frame_len_err}, {31'b0, f[0]});
        end
      end else begin
        check("flags_outside_done", {30'b0, frame_lrc_err, frame_len_err}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_par      = 1'b0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    clear_count = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_err_count", {16'b0, err_count}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Good frame
    good_frame();
    idle(3);
    check("good_err_count", {16'b0, err_count}, 32'd0);

    // Parity error on 07, then clear racing a second parity error
    frame_q.push_back(2'b00);
    send_word(8'h0F, 1'b0, 1'b0);
    send_word(8'h07, 1'b0, 1'b0);
    check("perr_count_one", {16'b0, err_count}, 32'd1);
    send_word(8'h01, 1'b1, 1'b0);
    send_word(8'h09, 1'b0, 1'b1);
    frame_q.push_back(2'b00);
    clear_count = 1'b1;
    send_word(8'h0F, 1'b1, 1'b0);
    clear_count = 1'b0;
    check("clear_wins", {16'b0, err_count}, 32'd0);
    send_word(8'h07, 1'b1, 1'b0);
    send_word(8'h01, 1'b1, 1'b0);
    send_word(8'h09, 1'b0, 1'b1);
    idle(3);

    // LRC error: last word 08 leaves residue 01
    frame_q.push_back(2'b10);
    send_word(8'h0F, 1'b0, 1'b0);
    send_word(8'h07, 1'b1, 1'b0);
    send_word(8'h01, 1'b1, 1'b0);
    send_word(8'h08, 1'b1, 1'b1);
    idle(3);

    // Short frame: last on word 2, LRC balanced
    frame_q.push_back(2'b01);
    send_word(8'h05, 1'b0, 1'b0);
    send_word(8'h05, 1'b0, 1'b1);
    idle(3);

    // Long frame: overrun reported at word 4, word 5 silently resyncs
    frame_q.push_back(2'b01);
    send_word(8'h01, 1'b1, 1'b0);
    send_word(8'h02, 1'b1, 1'b0);
    send_word(8'h04, 1'b1, 1'b0);
    send_word(8'h08, 1'b1, 1'b0);
    send_word(8'h0F, 1'b0, 1'b1);
    idle(3);
    good_frame();
    idle(3);

    // Backpressure: downstream stalls while upstream keeps offering
    out_ready = 1'b0;
    frame_q.push_back(2'b00);
    fork
      begin
        send_word(8'h03, 1'b0, 1'b0);
        send_word(8'h05, 1'b0, 1'b0);
        send_word(8'h06, 1'b0, 1'b0);
        send_word(8'h00, 1'b0, 1'b1);
      end
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", {31'b0, in_ready}, 32'd0);
          check("bp_hold_data", {24'b0, out_data}, 32'h03);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(3);

    // Reset in the middle of a frame discards it
    send_word(8'h0F, 1'b0, 1'b0);
    send_word(8'h07, 1'b0, 1'b0);
    idle(3);
    check("pre_rst_err_count", {16'b0, err_count}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_data", {24'b0, out_data}, 32'd0);
    check("mid_rst_out_par_err", {31'b0, out_par_err}, 32'd0);
    check("mid_rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("mid_rst_flags", {30'b0, frame_lrc_err, frame_len_err}, 32'd0);
    check("mid_rst_err_count", {16'b0, err_count}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    good_frame();
    idle(5);

    check("exp_q_drained", exp_q.size(), 32'd0);
    check("frame_q_drained", frame_q.size(), 32'd0);
    check("final_err_count", {16'b0, err_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 16: payload width in bits; legal range 1..64.
REQ-002 SHALL have parameter FRAME_LEN, default 4: words per frame, LRC word included; legal range 2..256.
REQ-003 SHALL have parameter ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  upstream word valid.
REQ-007 SHALL have port in_ready  output  1  checker can accept a word.
REQ-008 SHALL have port in_data  input  DATA_W  payload word.
REQ-009 SHALL have port in_par  input  1  transmitted parity bit.
REQ-010 SHALL have port in_last  input  1  word is the frame's LRC word.
REQ-011 SHALL have port out_valid  output  1  output word valid.
REQ-012 SHALL have port out_ready  input  1  downstream can accept.
REQ-013 SHALL have port out_data  output  DATA_W  forwarded payload.
REQ-014 SHALL have port out_par_err  output  1  per-word parity mismatch for out_data.
REQ-015 SHALL have port frame_done  output  1  one-cycle frame-end pulse.
REQ-016 SHALL have port frame_lrc_err  output  1  LRC mismatch; qualified by frame_done.
REQ-017 SHALL have port frame_len_err  output  1  length violation; qualified by frame_done.
REQ-018 SHALL have port clear_count  input  1  synchronous clear of err_count.
REQ-019 SHALL have port err_count  output  16  saturating parity-error count.

Function
REQ-020 SHALL define accept as the cycle where in_valid and in_ready are both high.
REQ-021 SHALL drive in_ready = !out_valid || out_ready, so no word is lost or duplicated.
REQ-022 SHALL compute expected parity as XOR-reduction of in_data, XORed with ODD_PARITY; out_par_err = (in_par != expected).
REQ-023 SHALL register out_data and out_par_err on accept; latency is 1 cycle; values SHALL be held stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid when out_ready is high and no accept occurs in that cycle.
REQ-025 SHALL keep a word counter and a DATA_W LRC accumulator (running XOR of every accepted word, LRC word included).
REQ-026 SHALL implement states IDLE, ACCUM and RESYNC.
REQ-027 IDLE: an accept without in_last SHALL go to ACCUM with count=1 and lrc=in_data.
REQ-028 IDLE: an accept with in_last SHALL end a 1-word frame with frame_len_err=1.
REQ-029 ACCUM: an accept with in_last SHALL end the frame and return to IDLE; frame_len_err=1 if count+1 != FRAME_LEN; frame_lrc_err=1 if (lrc ^ in_data) != 0.
REQ-030 ACCUM: an accept without in_last that makes count+1 == FRAME_LEN SHALL end the frame with frame_len_err=1 and frame_lrc_err=0, then go to RESYNC.
REQ-031 RESYNC: words SHALL still be forwarded and parity-checked, with no frame accounting; an accept with in_last SHALL return to IDLE without a frame_done pulse.
REQ-032 SHALL pulse frame_done for exactly one cycle, the cycle after the frame-ending accept; error flags SHALL be valid during the pulse and 0 otherwise.
REQ-033 SHALL increment err_count on each accept with a parity mismatch, saturating at 16'hFFFF.
REQ-034 SHALL give clear_count priority over a same-cycle increment: the count goes to 0 and that increment is dropped.

Reset
REQ-035 SHALL, on rst_n low, immediately force state IDLE and clear the counter and LRC accumulator.
REQ-036 SHALL, on rst_n low, drive out_valid, out_par_err, frame_done, frame_lrc_err and frame_len_err to 0.
REQ-037 SHALL, on rst_n low, drive out_data and err_count to 0.
REQ-038 SHALL discard any frame in progress when reset is asserted mid-frame; no frame_done follows.

Structure
REQ-039 SHALL place the state enum and parameter defaults in shared package parity_pkg.
REQ-040 SHALL instantiate one combinational sub-module, parity_word_check (data, par, odd -> err), reusable by a future generator.

Verification (DATA_W=8, FRAME_LEN=4, even parity)
REQ-041 Good frame: words 0F/p0, 07/p1, 01/p1, 09/p0+last -> four outputs with out_par_err=0; frame_done with both error flags 0; err_count=0.
REQ-042 Parity error: 07 sent with p0 -> out_par_err=1 on that output; err_count=1; then clear_count with a same-cycle error -> err_count=0.
REQ-043 LRC error: frame as in REQ-041 but last word 08/p1 -> frame_done with frame_lrc_err=1 and frame_len_err=0.
REQ-044 Length errors: last on word 2 -> frame_done with frame_len_err=1; 5 words, last on word 5 -> frame_len_err=1 at word 4, no pulse at word 5, then a good frame passes.
REQ-045 Backpressure: out_ready low for 3 cycles with in_valid high -> in_ready low, out_data held, no word lost or duplicated.
REQ-046 Reset mid-frame after 2 words -> all outputs 0 immediately; the next good frame passes cleanly.
